// File: rtl/btn_pkg.sv
// Shared definitions for the button debounce arbiter.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COUNT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_priority_select.sv
// Round-robin first-hit selector: scans from last_i+1 upward, wrapping mod N_BTN.
module rr_priority_select #(
    parameter int N_BTN = 4
) (
    input  logic [N_BTN-1:0]         req_i,
    input  logic [$clog2(N_BTN)-1:0] last_i,
    output logic                     hit_o,
    output logic [$clog2(N_BTN)-1:0] idx_o
);

    localparam int GW = $clog2(N_BTN);

    logic [GW-1:0] sel;

    // Walk from the farthest candidate to the nearest so the nearest hit is the last write.
    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        sel   = '0;
        for (int k = N_BTN; k >= 1; k--) begin
            sel = GW'((int'(last_i) + k) % N_BTN);
            if (req_i[sel]) begin
                hit_o = 1'b1;
                idx_o = sel;
            end
        end
    end

endmodule

// File: rtl/btn_debounce_arbiter.sv
// N_BTN buttons share one debounce timer; each accepted press yields one registered pulse.
module btn_debounce_arbiter
    import btn_pkg::*;
#(
    parameter int N_BTN        = 4,
    parameter int DELAY_CYCLES = 2000000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_BTN-1:0]         btn_i,
    output logic [N_BTN-1:0]         pulse_o,
    output logic                     busy_o,
    output logic [$clog2(N_BTN)-1:0] grant_o
);

    localparam int GW = $clog2(N_BTN);
    localparam int CW = $clog2(DELAY_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DELAY_CYCLES - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_q, last_d;
    logic [N_BTN-1:0] pulse_q, pulse_d;

    logic          sel_hit;
    logic [GW-1:0] sel_idx;

    rr_priority_select #(.N_BTN(N_BTN)) u_rr (
        .req_i  (btn_i),
        .last_i (last_q),
        .hit_o  (sel_hit),
        .idx_o  (sel_idx)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        pulse_d = '0;
        case (state_q)
            IDLE: begin
                if (sel_hit) begin
                    grant_d = sel_idx;
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!btn_i[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end else if (cnt_q == CNT_MAX) begin
                    state_d          = RELEASE;
                    pulse_d[grant_q] = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RELEASE: begin
                // Hold ownership until the button drops so a long press pulses once.
                if (!btn_i[grant_q]) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            last_q  <= GW'(N_BTN - 1);
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o = pulse_q;
    assign busy_o  = (state_q != IDLE);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_btn_debounce_arbiter.sv
// Directed and random stimulus against a press-level reference model of the arbiter.
module tb_btn_debounce_arbiter;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] btn;
    logic [N-1:0] pulse;
    logic         busy;
    logic [1:0]   grant;

    btn_debounce_arbiter #(.N_BTN(N), .DELAY_CYCLES(D)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .btn_i   (btn),
        .pulse_o (pulse),
        .busy_o  (busy),
        .grant_o (grant)
    );

    always #5 clk = ~clk;

    // Reference model: who owns the timer, how many consecutive high samples it has seen.
    int           m_busy  = 0;
    int           m_owner = 0;
    int           m_last  = N - 1;
    int           m_held  = 0;
    int           m_done  = 0;
    logic [N-1:0] m_pulse = '0;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;
    logic [N-1:0] plog[$];
    int           pcyc[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_step();
        logic [N-1:0] np;
        np = '0;
        if (rst) begin
            m_busy = 0; m_owner = 0; m_last = N - 1; m_held = 0; m_done = 0;
        end else if (m_busy == 0) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (btn[c] && m_busy == 0) begin
                    m_busy = 1; m_owner = c; m_held = 1; m_done = 0;
                end
            end
        end else if (!btn[m_owner]) begin
            m_busy = 0;
            m_last = m_owner;
        end else if (m_done == 0) begin
            m_held++;
            if (m_held == D + 1) begin
                np[m_owner] = 1'b1;
                m_done = 1;
            end
        end
        m_pulse = np;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        check("model_pulse", 32'(pulse), 32'(m_pulse));
        check("model_busy",  32'(busy),  32'(m_busy));
        check("model_grant", 32'(grant), 32'(m_owner));
        if (pulse != '0) begin
            plog.push_back(pulse);
            pcyc.push_back(cyc);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int s, n0, got2, saw0;
        logic [N-1:0] first, second;

        rst = 1'b1;
        btn = '0;
        ticks(2);
        check("rst_pulse", 32'(pulse), 32'h0);
        check("rst_busy",  32'(busy),  32'h0);
        check("rst_grant", 32'(grant), 32'h0);
        rst = 1'b0;
        tick();

        // Single held press: one pulse, D edges after the grant edge.
        s = cyc; n0 = plog.size();
        btn = 4'b0001;
        tick();
        check("hold_busy_after_grant", 32'(busy), 32'h1);
        ticks(19);
        check("hold_pulse_count", 32'(plog.size() - n0), 32'h1);
        if (plog.size() > n0) begin
            check("hold_pulse_val", 32'(plog[n0]), 32'h1);
            check("hold_pulse_cyc", 32'(pcyc[n0]), 32'(s + 1 + D));
        end
        check("hold_busy_held", 32'(busy), 32'h1);
        btn = '0;
        ticks(2);
        check("hold_busy_released", 32'(busy), 32'h0);

        // Short glitch on channel 2: aborted, grant retained.
        n0 = plog.size();
        btn = 4'b0100;
        ticks(3);
        btn = '0;
        ticks(2);
        check("abort_no_pulse", 32'(plog.size() - n0), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_grant", 32'(grant), 32'h2);

        // Two simultaneous presses from reset: channel 1 then channel 3.
        rst = 1'b1; tick(); rst = 1'b0;
        btn = 4'b1010; first = '0; second = '0;
        for (int i = 0; i < 40 && second == '0; i++) begin
            tick();
            if (pulse != '0) begin
                if (first == '0) first = pulse;
                else second = pulse;
                btn = btn & ~pulse;
            end
        end
        check("rr_first", 32'(first), 32'h2);
        check("rr_second", 32'(second), 32'h8);
        btn = '0; ticks(2);

        // Channel 0 repeatedly pressed while channel 2 held: channel 2 still served.
        rst = 1'b1; tick(); rst = 1'b0;
        got2 = 0; saw0 = 0;
        for (int i = 0; i < 60 && got2 == 0; i++) begin
            btn[2] = 1'b1;
            btn[0] = (i % 7) != 6;
            tick();
            if (pulse[0]) saw0 = 1;
            if (pulse[2]) got2 = 1;
        end
        check("starve_ch0_first", 32'(saw0), 32'h1);
        check("starve_ch2_served", 32'(got2), 32'h1);
        btn = '0; ticks(3);

        // Reset mid-count abandons the press; a fresh press then works.
        rst = 1'b1; tick(); rst = 1'b0;
        n0 = plog.size();
        btn = 4'b0001;
        ticks(3);
        rst = 1'b1; tick(); rst = 1'b0;
        check("midrst_pulse", 32'(pulse), 32'h0);
        check("midrst_busy",  32'(busy),  32'h0);
        check("midrst_grant", 32'(grant), 32'h0);
        check("midrst_none", 32'(plog.size() - n0), 32'h0);
        ticks(6);
        check("midrst_fresh", 32'(plog.size() - n0), 32'h1);
        btn = '0; ticks(2);

        // Long hold pulses once; a second press pulses again.
        n0 = plog.size();
        btn = 4'b0010;
        ticks(100);
        check("long_one_pulse", 32'(plog.size() - n0), 32'h1);
        btn = '0; ticks(2);
        btn = 4'b0010; ticks(10);
        check("long_second_pulse", 32'(plog.size() - n0), 32'h2);
        btn = '0; ticks(2);

        // Random bouncing buttons with occasional reset.
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(7) == 0) btn[b] = ~btn[b];
            rst = ($urandom_range(99) == 0);
            tick();
        end
        rst = 1'b0; btn = '0; ticks(3);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/btn_debounce_arbiter.md
BTN_DEBOUNCE_ARBITER -- requirements
Module: btn_debounce_arbiter

Interface
REQ-001 Parameter N_BTN, default 4: number of button requesters sharing the debounce timer; legal range 2..8.
REQ-002 Parameter DELAY_CYCLES, default 2000000: consecutive high samples required after grant before a press is accepted; legal minimum 2.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 btn_i  input  N_BTN  raw button levels, one bit per requester, already synchronous to clk_i.
REQ-006 pulse_o  output  N_BTN  one-hot, one-cycle pulse per accepted press on the owning channel.
REQ-007 busy_o  output  1  high whenever the shared timer is granted (any state other than IDLE).
REQ-008 grant_o  output  $clog2(N_BTN)  index of the channel currently owning the timer; holds last owner when idle.

Function
REQ-009 Controller SHALL be a three-state FSM: IDLE, COUNT, RELEASE.
REQ-010 IDLE: SHALL select the first high btn_i bit in round-robin order, starting at index (last_grant+1) mod N_BTN; on a hit, load grant, clear counter to 0, go to COUNT; no hit, stay IDLE.
REQ-011 COUNT: granted bit low -> abort to IDLE, no pulse, last_grant updated to the aborted channel.
REQ-012 COUNT: granted bit high and counter < DELAY_CYCLES-1 -> counter increments by 1, stay COUNT.
REQ-013 COUNT: granted bit high and counter == DELAY_CYCLES-1 -> go to RELEASE and assert pulse_o[grant] on the next cycle only.
REQ-014 Latency: with grant taken at edge e0, pulse_o SHALL be visible for exactly the cycle following edge e0+DELAY_CYCLES, given DELAY_CYCLES+1 consecutive high samples e0..e0+DELAY_CYCLES.
REQ-015 RELEASE: SHALL wait until granted bit is low, then go to IDLE with last_grant = grant; exactly one pulse per press however long held.
REQ-016 Other channels pressed during COUNT/RELEASE SHALL be ignored until IDLE; served then only if still high.
REQ-017 Simultaneous presses in IDLE SHALL be served one at a time in round-robin order; no channel starves while others repeatedly press.
REQ-018 pulse_o SHALL be registered, never more than one bit high, and zero in every cycle except the one defined in REQ-014.
REQ-019 Counter width SHALL be $clog2(DELAY_CYCLES) bits; counter never exceeds DELAY_CYCLES-1 and never wraps.
REQ-020 busy_o and grant_o SHALL be driven from registers (no combinational path from btn_i).

Reset
REQ-021 On rst_i high at a clock edge: state IDLE, counter 0, pulse_o 0, busy_o 0, grant_o 0, last_grant N_BTN-1 (channel 0 highest priority first).
REQ-022 Reset asserted mid-COUNT or mid-RELEASE SHALL abandon the press with no pulse; reset dominates all other inputs that cycle.

Structure
REQ-023 Shared package btn_pkg SHALL hold the FSM state enum (IDLE, COUNT, RELEASE) as a 2-bit logic typedef.
REQ-024 Round-robin selection SHALL be one combinational sub-module rr_priority_select (inputs: request vector, last grant; outputs: hit, index).
REQ-025 FSM, counter and output registers reside in btn_debounce_arbiter; no other sub-modules.

Verification (DELAY_CYCLES=4, N_BTN=4)
REQ-026 btn_i=0001 held 20 cycles -> single pulse_o=0001 one cycle, 4 edges after grant edge; busy_o high until release.
REQ-027 btn_i[2] high 3 cycles then low -> no pulse, FSM returns to IDLE, grant_o=2 retained.
REQ-028 btn_i=1010 from reset, held, each released after its pulse -> pulse on channel 1 first, then channel 3.
REQ-029 Channel 0 pressed repeatedly while channel 2 held continuously -> channel 2 pulses after channel 0's first press completes, not starved.
REQ-030 rst_i asserted at counter==2 with btn_i[0] high -> no pulse, all outputs at reset values next cycle; fresh press afterwards pulses normally.
REQ-031 Channel 1 held 100 cycles -> exactly one pulse; second press after release -> second pulse.
